// File: rtl/watcher_capture_buf_if.sv
// rtl/watcher_capture_buf_if.sv - trigger-node write/stop and host readout signals of watcher_capture_buf (WATCHER_CAPBUF_PARITY_EN adds rd_perr)
interface watcher_capture_buf_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
);
  logic              arm;
  logic [DATA_W-1:0] probe_din;
  logic              wt_ce;
  logic              wt_en;
  logic [ADDR_W-1:0] wt_addr;
  logic              stop_flag;
  logic [ADDR_W-1:0] stop_addr;
  logic              overflow_flag;
  logic              pause;
  logic              buf_ready;
  logic [ADDR_W-1:0] sample_cnt;
  logic              ovf_seen;
  logic              addr_err;
  logic              rd_req;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              rd_last;
`ifdef WATCHER_CAPBUF_PARITY_EN
  logic              rd_perr;
`endif

  // Trigger node and host side: drives capture and read requests.
  modport master (
    output arm, probe_din, wt_ce, wt_en, wt_addr, stop_flag, stop_addr,
           overflow_flag, rd_req,
`ifdef WATCHER_CAPBUF_PARITY_EN
    input  rd_perr,
`endif
    input  pause, buf_ready, sample_cnt, ovf_seen, addr_err,
           rd_data, rd_valid, rd_last
  );

  // Capture buffer side.
  modport slave (
    input  arm, probe_din, wt_ce, wt_en, wt_addr, stop_flag, stop_addr,
           overflow_flag, rd_req,
`ifdef WATCHER_CAPBUF_PARITY_EN
    output rd_perr,
`endif
    output pause, buf_ready, sample_cnt, ovf_seen, addr_err,
           rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/watcher_capture_buf.sv
// rtl/watcher_capture_buf.sv - capture RAM with oldest-first readout behind the watcher trigger node (optional WATCHER_CAPBUF_PARITY_EN)
module watcher_capture_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 16
) (
  input  logic                  trig_clk,
  input  logic                  trig_rstn,
  watcher_capture_buf_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so a count of exactly DEPTH is representable even at DEPTH=65536.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
`ifdef WATCHER_CAPBUF_PARITY_EN
  localparam int RAM_W = DATA_W + 1;
`else
  localparam int RAM_W = DATA_W;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DONE    = 2'd2,
    S_READ    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;
  logic               ovf_seen_q, ovf_seen_d;
  logic               addr_err_q, addr_err_d;
  logic [IDX_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   remain_q, remain_d;
  logic [IDX_W-1:0]   rd_addr_q, rd_addr_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_pend_last_q, rd_pend_last_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
`ifdef WATCHER_CAPBUF_PARITY_EN
  logic               rd_perr_q, rd_perr_d;
`endif

  logic [RAM_W-1:0]   mem [DEPTH];
  logic [RAM_W-1:0]   wr_word;
  logic [RAM_W-1:0]   rd_word;
  logic               wr_ok;
  logic               rd_accept;

`ifdef WATCHER_CAPBUF_PARITY_EN
  assign wr_word = {^bus.probe_din, bus.probe_din};
`else
  assign wr_word = bus.probe_din;
`endif
  assign rd_word = mem[rd_addr_q];

  // Next-state, capture bookkeeping and the two-stage read pipeline.
  always_comb begin
    state_d        = state_q;
    sample_cnt_d   = sample_cnt_q;
    ovf_seen_d     = ovf_seen_q;
    addr_err_d     = addr_err_q;
    rd_ptr_d       = rd_ptr_q;
    remain_d       = remain_q;
    rd_addr_d      = rd_addr_q;
    rd_pend_d      = 1'b0;
    rd_pend_last_d = rd_pend_last_q;
    rd_data_d      = rd_data_q;
    rd_valid_d     = 1'b0;
    rd_last_d      = 1'b0;
    wr_ok          = 1'b0;
    rd_accept      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.arm) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (bus.wt_ce && bus.wt_en) begin
          if ({1'b0, bus.wt_addr} < DEPTH_C) begin
            wr_ok = 1'b1;
            if (sample_cnt_q != DEPTH_C) sample_cnt_d = sample_cnt_q + 1'b1;
          end else begin
            addr_err_d = 1'b1;
          end
        end
        if (bus.overflow_flag) ovf_seen_d = 1'b1;
        if (bus.stop_flag) begin
          state_d  = S_DONE;
          // Use the count including a same-cycle write so the window is exact.
          remain_d = sample_cnt_d;
          if (sample_cnt_d == DEPTH_C && {1'b0, bus.stop_addr} < LAST_C)
            rd_ptr_d = bus.stop_addr[IDX_W-1:0] + 1'b1;
          else
            rd_ptr_d = '0;
        end
      end
      S_DONE: begin
        if (remain_q == '0) begin
          state_d = S_IDLE;
        end else if (bus.rd_req && !rd_pend_q) begin
          rd_accept = 1'b1;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (bus.rd_req && !rd_pend_q && remain_q != '0) rd_accept = 1'b1;
        if (rd_valid_q && rd_last_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_accept) begin
      rd_addr_d      = rd_ptr_q;
      rd_ptr_d       = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + 1'b1;
      remain_d       = remain_q - 1'b1;
      rd_pend_d      = 1'b1;
      rd_pend_last_d = (remain_q == CNT_W'(1));
    end

    if (rd_pend_q) begin
      rd_data_d  = rd_word[DATA_W-1:0];
      rd_valid_d = 1'b1;
      rd_last_d  = rd_pend_last_q;
    end

`ifdef WATCHER_CAPBUF_PARITY_EN
    // Even parity over data plus stored bit is zero for an intact word.
    rd_perr_d = rd_pend_q && (^rd_word);
`endif

    // arm overrides everything, including a read already in flight.
    if (bus.arm) begin
      state_d      = S_CAPTURE;
      sample_cnt_d = '0;
      ovf_seen_d   = 1'b0;
      addr_err_d   = 1'b0;
      remain_d     = '0;
      rd_pend_d    = 1'b0;
      rd_valid_d   = 1'b0;
      rd_last_d    = 1'b0;
      rd_data_d    = rd_data_q;
      wr_ok        = 1'b0;
`ifdef WATCHER_CAPBUF_PARITY_EN
      rd_perr_d    = 1'b0;
`endif
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge trig_clk) begin
    if (!trig_rstn) begin
      state_q        <= S_IDLE;
      sample_cnt_q   <= '0;
      ovf_seen_q     <= 1'b0;
      addr_err_q     <= 1'b0;
      rd_ptr_q       <= '0;
      remain_q       <= '0;
      rd_addr_q      <= '0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
      rd_last_q      <= 1'b0;
`ifdef WATCHER_CAPBUF_PARITY_EN
      rd_perr_q      <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      sample_cnt_q   <= sample_cnt_d;
      ovf_seen_q     <= ovf_seen_d;
      addr_err_q     <= addr_err_d;
      rd_ptr_q       <= rd_ptr_d;
      remain_q       <= remain_d;
      rd_addr_q      <= rd_addr_d;
      rd_pend_q      <= rd_pend_d;
      rd_pend_last_q <= rd_pend_last_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
      rd_last_q      <= rd_last_d;
`ifdef WATCHER_CAPBUF_PARITY_EN
      rd_perr_q      <= rd_perr_d;
`endif
    end
  end

  // Sample RAM; contents are not reset.
  always_ff @(posedge trig_clk) begin
    if (wr_ok) mem[bus.wt_addr[IDX_W-1:0]] <= wr_word;
  end

  assign bus.pause      = (state_q != S_CAPTURE);
  assign bus.buf_ready  = (state_q == S_DONE) || (state_q == S_READ);
  assign bus.sample_cnt = sample_cnt_q[ADDR_W-1:0];
  assign bus.ovf_seen   = ovf_seen_q;
  assign bus.addr_err   = addr_err_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_last    = rd_last_q;
`ifdef WATCHER_CAPBUF_PARITY_EN
  assign bus.rd_perr    = rd_perr_q;
`endif

endmodule

// File: tb/tb_watcher_capture_buf.sv
// tb/tb_watcher_capture_buf.sv - scoreboard bench for watcher_capture_buf (parity case under WATCHER_CAPBUF_PARITY_EN)
module tb_watcher_capture_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 16;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              perr;
  } exp_t;

  logic trig_clk;
  logic trig_rstn;
  int   checks;
  int   failures;
  exp_t exp_q[$];

  watcher_capture_buf_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  watcher_capture_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .trig_clk  (trig_clk),
    .trig_rstn (trig_rstn),
    .bus       (bus)
  );

  initial trig_clk = 1'b0;
  always #5 trig_clk = ~trig_clk;

  // Monitor: every rd_valid pops the next expected word.
  always @(negedge trig_clk) begin
    if (trig_rstn && bus.rd_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_rd_valid: rd_data=%02h with no expected word", bus.rd_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.rd_data !== e.data || bus.rd_last !== e.last) begin
          failures++;
          $display("FAIL rd_word: got data=%02h last=%0b, want data=%02h last=%0b",
                   bus.rd_data, bus.rd_last, e.data, e.last);
        end
`ifdef WATCHER_CAPBUF_PARITY_EN
        checks++;
        if (bus.rd_perr !== e.perr) begin
          failures++;
          $display("FAIL rd_perr: got %0b want %0b (data=%02h)", bus.rd_perr, e.perr, e.data);
        end
`endif
      end
    end
  end

  task automatic tick();
    @(posedge trig_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.wt_ce = 1'b1; bus.wt_en = 1'b1; bus.wt_addr = a; bus.probe_din = d;
    tick();
    bus.wt_ce = 1'b0; bus.wt_en = 1'b0;
  endtask

  task automatic do_stop(input logic [ADDR_W-1:0] a);
    bus.stop_flag = 1'b1; bus.stop_addr = a;
    tick();
    bus.stop_flag = 1'b0;
  endtask

  // Request one word; with hold=1 the request stays high while the read is in flight.
  task automatic read_word(input logic [DATA_W-1:0] d, input logic last, input logic perr,
                           input logic hold);
    exp_t e;
    e.data = d; e.last = last; e.perr = perr;
    exp_q.push_back(e);
    bus.rd_req = 1'b1;
    tick();
    if (!hold) bus.rd_req = 1'b0;
    tick();
    bus.rd_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    int a;
    checks = 0; failures = 0;
    bus.arm = 0; bus.probe_din = 0; bus.wt_ce = 0; bus.wt_en = 0; bus.wt_addr = 0;
    bus.stop_flag = 0; bus.stop_addr = 0; bus.overflow_flag = 0; bus.rd_req = 0;
    trig_rstn = 1'b0;
    repeat (3) tick();
    trig_rstn = 1'b1;

    chk("rst_pause", bus.pause, 1);
    chk("rst_buf_ready", bus.buf_ready, 0);
    chk("rst_sample_cnt", bus.sample_cnt, 0);
    chk("rst_ovf_seen", bus.ovf_seen, 0);
    chk("rst_addr_err", bus.addr_err, 0);
    chk("rst_rd_out", {bus.rd_data, bus.rd_valid, bus.rd_last}, 0);

    // Linear capture of 10 words.
    do_arm();
    chk("t1_pause_low", bus.pause, 0);
    for (int i = 0; i < 10; i++) do_write(ADDR_W'(i), 8'hA0 + 8'(i));
    do_stop(16'd9);
    chk("t1_pause_high", bus.pause, 1);
    chk("t1_buf_ready", bus.buf_ready, 1);
    chk("t1_sample_cnt", bus.sample_cnt, 10);
    for (int i = 0; i < 10; i++) read_word(8'hA0 + 8'(i), i == 9, 1'b0, 1'b0);
    tick();
    chk("t1_buf_ready_drop", bus.buf_ready, 0);
    chk("t1_pause_stays", bus.pause, 1);

    // Wrapped capture: 20 writes into 16 words.
    do_arm();
    for (int i = 0; i < 20; i++) do_write(ADDR_W'(i % 16), 8'h10 + 8'(i));
    do_stop(16'd3);
    chk("t2_sample_cnt", bus.sample_cnt, 16);
    for (int k = 0; k < 16; k++) begin
      a = (4 + k) % 16;
      d = (a < 4) ? 8'h20 + 8'(a) : 8'h10 + 8'(a);
      read_word(d, k == 15, 1'b0, 1'b0);
    end
    tick();
    chk("t2_buf_ready_drop", bus.buf_ready, 0);

    // Out-of-range write and overflow flag.
    do_arm();
    do_write(16'd0, 8'h55);
    do_write(16'(DEPTH), 8'hEE);
    chk("t3_addr_err", bus.addr_err, 1);
    chk("t3_sample_cnt", bus.sample_cnt, 1);
    bus.overflow_flag = 1'b1;
    tick();
    bus.overflow_flag = 1'b0;
    chk("t3_ovf_seen", bus.ovf_seen, 1);
    do_stop(16'd0);
    read_word(8'h55, 1'b1, 1'b0, 1'b0);
    tick();

    // arm during readout aborts the pending request.
    do_arm();
    chk("t4_sticky_cleared", {bus.ovf_seen, bus.addr_err}, 0);
    for (int i = 0; i < 6; i++) do_write(ADDR_W'(i), 8'h30 + 8'(i));
    do_stop(16'd5);
    for (int i = 0; i < 3; i++) read_word(8'h30 + 8'(i), 1'b0, 1'b0, 1'b0);
    bus.rd_req = 1'b1;
    tick();
    bus.rd_req = 1'b0;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk("t4_pause_low", bus.pause, 0);
    chk("t4_sample_cnt", bus.sample_cnt, 0);
    chk("t4_no_rd_valid", bus.rd_valid, 0);
    chk("t4_buf_ready", bus.buf_ready, 0);

    // Write coincident with stop; requests held during in-flight reads.
    for (int i = 0; i < 5; i++) do_write(ADDR_W'(i), 8'h40 + 8'(i));
    bus.wt_ce = 1'b1; bus.wt_en = 1'b1; bus.wt_addr = 16'd5; bus.probe_din = 8'h45;
    bus.stop_flag = 1'b1; bus.stop_addr = 16'd5;
    tick();
    bus.wt_ce = 1'b0; bus.wt_en = 1'b0; bus.stop_flag = 1'b0;
    chk("t5_sample_cnt", bus.sample_cnt, 6);
    for (int i = 0; i < 6; i++) read_word(8'h40 + 8'(i), i == 5, 1'b0, 1'b1);
    tick();
    chk("t5_idle", bus.buf_ready, 0);
    bus.rd_req = 1'b1;
    repeat (4) tick();
    bus.rd_req = 1'b0;
    repeat (2) tick();
    chk("t5_rd_data_hold", bus.rd_data, 8'h45);

`ifdef WATCHER_CAPBUF_PARITY_EN
    // Corrupt the stored parity bit of one word.
    do_arm();
    for (int i = 0; i < 3; i++) do_write(ADDR_W'(i), 8'h61 + 8'(i));
    do_stop(16'd2);
    dut.mem[1][DATA_W] = ~dut.mem[1][DATA_W];
    for (int i = 0; i < 3; i++) read_word(8'h61 + 8'(i), i == 2, i == 1, 1'b0);
    repeat (2) tick();
`endif

    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/watcher_capture_buf.md
# watcher_capture_buf

Sample store and readout stage directly downstream of the watcher trigger node.
- Writes one probe word per trigger-node write strobe into an internal RAM at the address the trigger node supplies.
- Freezes on the trigger node's stop flag and then plays the captured window back, oldest sample first, one word per host request.
- Holds the trigger node paused while idle or reading out, so the buffer is never overwritten during readout.

## Interface
Parameters:
- DATA_W, 8, probe word width
- DEPTH, 4096, RAM depth in words; legal range 2..65536, not required to be a power of two
- ADDR_W, 16, width of address and count ports; fixed to match the trigger node

Ports:
- trig_clk  in  1  the single clock for the block
- trig_rstn  in  1  reset; synchronous, active-low, sampled on the rising edge of trig_clk
- arm  in  1  one-cycle pulse; starts a new capture
- probe_din  in  DATA_W  probe sample
- wt_ce  in  1  write chip enable from the trigger node
- wt_en  in  1  write enable from the trigger node
- wt_addr  in  ADDR_W  write address from the trigger node
- stop_flag  in  1  capture complete, from the trigger node
- stop_addr  in  ADDR_W  address of the last written sample
- overflow_flag  in  1  trigger node overflow indication
- pause  out  1  to the trigger node; freezes it
- buf_ready  out  1  capture frozen, readout available
- sample_cnt  out  ADDR_W  number of valid stored words
- ovf_seen  out  1  sticky copy of overflow_flag during capture
- addr_err  out  1  sticky; set by a write with wt_addr >= DEPTH
- rd_req  in  1  one-cycle request for the next word
- rd_data  out  DATA_W  readout word
- rd_valid  out  1  one-cycle pulse qualifying rd_data
- rd_last  out  1  asserted together with rd_valid on the final word

## Operation
States:
- IDLE: state after reset; pause=1; writes ignored.
  - arm moves the block to CAPTURE.
  - stop_flag and rd_req are ignored.
- CAPTURE: pause=0.
  - A write is accepted when wt_ce && wt_en && wt_addr < DEPTH; it stores probe_din at wt_addr.
  - Each accepted write increments sample_cnt, saturating at DEPTH.
  - A write with wt_addr >= DEPTH is dropped and sets addr_err.
  - overflow_flag=1 sets ovf_seen.
  - stop_flag moves the block to DONE. A write in the same cycle as stop_flag is still accepted.
  - stop_addr is latched in the cycle stop_flag is seen.
- DONE: pause=1, buf_ready=1; writes ignored.
  - The read pointer is loaded on entry:
    - sample_cnt == DEPTH (wrapped): pointer = stop_addr+1, with DEPTH-1 wrapping to 0.
    - otherwise: pointer = 0.
  - The remaining-word counter is loaded with sample_cnt.
  - The first accepted rd_req moves the block to READ.
  - sample_cnt == 0 moves the block to IDLE in the next cycle, with buf_ready dropping.
- READ: pause=1, buf_ready=1.
  - Each accepted rd_req reads the word at the pointer, then advances the pointer (DEPTH-1 wraps to 0) and decrements the remaining counter.
  - On the final word the block returns to IDLE and buf_ready drops.

Rules in every state:
- arm in any state forces CAPTURE next cycle and clears sample_cnt, ovf_seen, addr_err, and the remaining counter. In DONE or READ this aborts readout, and no rd_valid is issued for a pending request.
- rd_req is ignored outside DONE/READ and while a read is in flight.
- Simultaneous arm and rd_req: arm wins.

## Timing
- Reset values: pause=1, buf_ready=0, sample_cnt=0, ovf_seen=0, addr_err=0, rd_data=0, rd_valid=0, rd_last=0, state IDLE. RAM contents are undefined.
- Writes take effect at the rising edge where the write conditions are met. sample_cnt shows the new value one cycle later.
- pause:
  - falls the cycle after arm.
  - rises the cycle after stop_flag is sampled.
- Read latency: rd_req in cycle N gives the RAM read in N+1 and rd_data/rd_valid registered in N+2. A new rd_req is accepted from N+2 onward, so maximum throughput is one word per 2 cycles.
- rd_data holds its last value until the next rd_valid.
- The transition from READ to IDLE takes effect in the cycle after rd_last.

## Configuration
- WATCHER_CAPBUF_PARITY_EN defined:
  - The RAM is DATA_W+1 bits wide and stores even parity of probe_din with each word.
  - An extra output rd_perr (1 bit) is asserted with rd_valid when the stored parity mismatches the word read. rd_perr resets to 0.
- Undefined: no parity bit is stored and the rd_perr port does not exist.

## Test plan
- Reset then arm, 10 writes to addresses 0..9 with data 0xA0..0xA9, then stop_flag with stop_addr=9 -> sample_cnt=10; 10 rd_req return 0xA0..0xA9 at 2-cycle latency; rd_last on 0xA9; buf_ready drops and pause stays 1.
- DEPTH=16, 20 writes with addresses wrapping 0..15,0..3, stop_addr=3 -> sample_cnt=16; readout starts at address 4 and ends at address 3 with rd_last.
- Write to wt_addr=DEPTH during CAPTURE -> addr_err=1, sample_cnt unchanged, RAM unchanged.
- arm during READ after 3 words -> pending request yields no rd_valid, pause=0 next cycle, sample_cnt=0.
- Write and stop_flag in the same cycle at stop_addr=5 (not wrapped) -> word at 5 is stored; sample_cnt=6; a rd_req in IDLE or during an in-flight read produces no extra rd_valid.
- With WATCHER_CAPBUF_PARITY_EN, a single RAM bit forced in the bench -> rd_perr=1 on that word only.
